// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I controller: opcodes, FSM states,
// datapath select codes and the control-word struct produced by the decoder.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_JALRPC   = 4'd12,
    S_TRAP     = 4'd13
  } state_t;

  localparam logic [1:0] A_PC    = 2'b00;
  localparam logic [1:0] A_OLDPC = 2'b01;
  localparam logic [1:0] A_RS1   = 2'b10;

  localparam logic [1:0] B_RS2   = 2'b00;
  localparam logic [1:0] B_IMM   = 2'b01;
  localparam logic [1:0] B_FOUR  = 2'b10;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // rdy_gated marks states whose IRWrite/PCUpdate only fire on MemReady.
  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       ir_write;
    logic       pc_update;
    logic       rdy_gated;
    logic       branch;
    logic       reg_write;
    logic       illegal;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;
    logic [1:0] imm_src;
  } ctrl_t;

  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_SW:   return IMM_S;
      OP_B:    return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational Moore decode: current state (plus op for ImmSrc) to control word.
module mc_ctrl_decode
  import riscv_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [6:0] op,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl         = '0;
    ctrl.imm_src = imm_src_of(op);
    case (state)
      S_FETCH: begin
        ctrl.mem_req    = 1'b1;
        ctrl.adr_src    = 1'b0;
        ctrl.ir_write   = 1'b1;
        ctrl.pc_update  = 1'b1;
        ctrl.rdy_gated  = 1'b1;
        ctrl.alu_src_a  = A_PC;
        ctrl.alu_src_b  = B_FOUR;
        ctrl.result_src = RES_ALURESULT;
      end
      S_DECODE: begin
        ctrl.alu_src_a = A_OLDPC;
        ctrl.alu_src_b = B_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = A_RS1;
        ctrl.alu_src_b = B_IMM;
      end
      S_MEMREAD: begin
        ctrl.mem_req = 1'b1;
        ctrl.adr_src = 1'b1;
      end
      S_MEMWB: begin
        ctrl.result_src = RES_DATA;
        ctrl.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl.mem_req   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.adr_src   = 1'b1;
      end
      S_EXECR: begin
        ctrl.alu_src_a = A_RS1;
        ctrl.alu_src_b = B_RS2;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_EXECI: begin
        ctrl.alu_src_a = A_RS1;
        ctrl.alu_src_b = B_IMM;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.reg_write  = 1'b1;
      end
      S_BEQ: begin
        ctrl.alu_src_a = A_RS1;
        ctrl.alu_src_b = B_RS2;
        ctrl.alu_op    = ALU_SUB;
        ctrl.branch    = 1'b1;
      end
      // Both link states compute PC+4 from OldPC while the target sits in ALUOut.
      S_JAL, S_JALRPC: begin
        ctrl.alu_src_a  = A_OLDPC;
        ctrl.alu_src_b  = B_FOUR;
        ctrl.result_src = RES_ALUOUT;
        ctrl.pc_update  = 1'b1;
      end
      S_JALR: begin
        ctrl.alu_src_a = A_RS1;
        ctrl.alu_src_b = B_IMM;
      end
      S_TRAP: ctrl.illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I sequencer: state register, next-state logic, MemReady
// gating of fetch strobes, PCWrite combine and retired-instruction counter.
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       op,
  input  logic             Zero,
  input  logic             MemReady,
  output logic             MemReq,
  output logic             MemWrite,
  output logic             AdrSrc,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ImmSrc,
  output logic             Illegal,
  output logic [CNT_W-1:0] InstrCount
);

  state_t state, state_nxt;
  ctrl_t  cw;
  logic   retire;
  logic   pc_update;

  mc_ctrl_decode u_dec (
    .state (state),
    .op    (op),
    .ctrl  (cw)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:    if (MemReady) state_nxt = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_R:         state_nxt = S_EXECR;
          OP_I:         state_nxt = S_EXECI;
          OP_B:         state_nxt = S_BEQ;
          OP_JAL:       state_nxt = S_JAL;
          OP_JALR:      state_nxt = S_JALR;
          default:      state_nxt = S_TRAP;
        endcase
      end
      S_MEMADR:   state_nxt = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (MemReady) state_nxt = S_MEMWB;
      S_MEMWRITE: if (MemReady) state_nxt = S_FETCH;
      S_MEMWB:    state_nxt = S_FETCH;
      S_EXECR:    state_nxt = S_ALUWB;
      S_EXECI:    state_nxt = S_ALUWB;
      S_ALUWB:    state_nxt = S_FETCH;
      S_BEQ:      state_nxt = S_FETCH;
      S_JAL:      state_nxt = S_ALUWB;
      S_JALR:     state_nxt = S_JALRPC;
      S_JALRPC:   state_nxt = S_ALUWB;
      S_TRAP:     state_nxt = S_FETCH;
      default:    state_nxt = S_FETCH;
    endcase
  end

  // A trapped instruction returns to FETCH but is not counted as retired.
  assign retire = (state_nxt == S_FETCH) && (state != S_FETCH) && (state != S_TRAP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_FETCH;
      InstrCount <= '0;
    end else begin
      state <= state_nxt;
      if (retire) InstrCount <= InstrCount + CNT_W'(1);
    end
  end

  assign pc_update = cw.pc_update & (~cw.rdy_gated | MemReady);

  // Write strobes are masked by rst directly so a reset mid-store never commits.
  assign MemReq    = ~rst & cw.mem_req;
  assign MemWrite  = ~rst & cw.mem_write;
  assign IRWrite   = ~rst & cw.ir_write & MemReady;
  assign PCWrite   = ~rst & (pc_update | (cw.branch & Zero));
  assign RegWrite  = ~rst & cw.reg_write;
  assign Illegal   = ~rst & cw.illegal;
  assign AdrSrc    = cw.adr_src;
  assign ALUSrcA   = cw.alu_src_a;
  assign ALUSrcB   = cw.alu_src_b;
  assign ALUOp     = cw.alu_op;
  assign ResultSrc = cw.result_src;
  assign ImmSrc    = cw.imm_src;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed per-cycle vector bench for multicycle_controller, plus hand-written
// reset and instruction-latency sequences.
module tb_multicycle_controller;

  localparam logic [6:0] R    = 7'b0110011;
  localparam logic [6:0] IA   = 7'b0010011;
  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] BEQ  = 7'b1100011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111;
  localparam logic [6:0] BAD  = 7'b1111111;

  logic        clk = 1'b0;
  logic        rst, Zero, MemReady;
  logic [6:0]  op;
  logic        MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, Illegal;
  logic [1:0]  ALUSrcA, ALUSrcB, ALUOp, ResultSrc, ImmSrc;
  logic [31:0] InstrCount;

  int checks = 0;
  int errors = 0;

  multicycle_controller #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .op(op), .Zero(Zero), .MemReady(MemReady),
    .MemReq(MemReq), .MemWrite(MemWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .Illegal(Illegal),
    .InstrCount(InstrCount)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic [6:0]  op;
    logic        rdy;
    logic        zero;
    logic [16:0] word;
    logic [31:0] cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [16:0] cw(input logic mreq, mw, adr, irw, pcw, rw, ill,
                                     input logic [1:0] a, b, aop, res, imm);
    return {mreq, mw, adr, irw, pcw, rw, ill, a, b, aop, res, imm};
  endfunction

  function automatic logic [16:0] act_word();
    return {MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, Illegal,
            ALUSrcA, ALUSrcB, ALUOp, ResultSrc, ImmSrc};
  endfunction

  task automatic add(input logic r, input logic [6:0] o, input logic rdy, z,
                     input logic [16:0] w, input logic [31:0] c);
    vec_t v;
    v = '{rst: r, op: o, rdy: rdy, zero: z, word: w, cnt: c};
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic latency(input logic [6:0] o, input int exp);
    int n;
    op = o; MemReady = 1'b1; Zero = 1'b0;
    @(posedge clk); #1;
    n = 1;
    while (!IRWrite && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk($sformatf("latency op=%b", o), n, exp);
  endtask

  initial begin
    // Test 1: R-type, zero-wait; op scrambled in ALUWB must not matter
    add(0, R,   1, 0, cw(1,0,0,1,1,0,0, 2'd0,2'd2,2'd0,2'd2,2'd0), 0);
    add(0, R,   1, 0, cw(0,0,0,0,0,0,0, 2'd1,2'd1,2'd0,2'd0,2'd0), 0);
    add(0, R,   1, 0, cw(0,0,0,0,0,0,0, 2'd2,2'd0,2'd2,2'd0,2'd0), 0);
    add(0, BAD, 1, 0, cw(0,0,0,0,0,1,0, 2'd0,2'd0,2'd0,2'd0,2'd0), 0);
    // Test 2: lw, 2 waits in FETCH and 3 in MEMREAD
    add(0, LW, 0, 0, cw(1,0,0,0,0,0,0, 2'd0,2'd2,2'd0,2'd2,2'd0), 1);
    add(0, LW, 0, 0, cw(1,0,0,0,0,0,0, 2'd0,2'd2,2'd0,2'd2,2'd0), 1);
    add(0, LW, 1, 0, cw(1,0,0,1,1,0,0, 2'd0,2'd2,2'd0,2'd2,2'd0), 1);
    add(0, LW, 0, 0, cw(0,0,0,0,0,0,0, 2'd1,2'd1,2'd0,2'd0,2'd0), 1);
    add(0, LW, 1, 0, cw(0,0,0,0,0,0,0, 2'd2,2'd1,2'd0,2'd0,2'd0), 1);
    add(0, LW, 0, 0, cw(1,0,1,0,0,0,0, 2'd0,2'd0,2'd0,2'd0,2'd0), 1);
    add(0, LW, 0, 0, cw(1,0,1,0,0,0,0, 2'd0,2'd0,2'd0,2'd0,2'd0), 1);
    add(0, LW, 0, 0, cw(1,0,1,0,0,0,0, 2'd0,2'd0,2'd0,2'd0,2'd0), 1);
    add(0, LW, 1, 0, cw(1,0,1,0,0,0,0, 2'd0,2'd0,2'd0,2'd0,2'd0), 1);
    add(0, LW, 0, 0, cw(0,0,0,0,0,1,0, 2'd0,2'd0,2'd0,2'd1,2'd0), 1);
    // Test 3: beq taken (Zero high in DECODE must not write PC), then not taken
    add(0, BEQ, 1, 0, cw(1,0,0,1,1,0,0, 2'd0,2'd2,2'd0,2'd2,2'd2), 2);
    add(0, BEQ, 0, 1, cw(0,0,0,0,0,0,0, 2'd1,2'd1,2'd0,2'd0,2'd2), 2);
    add(0, BEQ, 0, 1, cw(0,0,0,0,1,0,0, 2'd2,2'd0,2'd1,2'd0,2'd2), 2);
    add(0, BEQ, 1, 0, cw(1,0,0,1,1,0,0, 2'd0,2'd2,2'd0,2'd2,2'd2), 3);
    add(0, BEQ, 1, 0, cw(0,0,0,0,0,0,0, 2'd1,2'd1,2'd0,2'd0,2'd2), 3);
    add(0, BEQ, 1, 0, cw(0,0,0,0,0,0,0, 2'd2,2'd0,2'd1,2'd0,2'd2), 3);
    // Test 4: jalr; PCWrite in JALRPC does not depend on MemReady
    add(0, JALR, 1, 0, cw(1,0,0,1,1,0,0, 2'd0,2'd2,2'd0,2'd2,2'd0), 4);
    add(0, JALR, 1, 0, cw(0,0,0,0,0,0,0, 2'd1,2'd1,2'd0,2'd0,2'd0), 4);
    add(0, JALR, 1, 0, cw(0,0,0,0,0,0,0, 2'd2,2'd1,2'd0,2'd0,2'd0), 4);
    add(0, JALR, 0, 0, cw(0,0,0,0,1,0,0, 2'd1,2'd2,2'd0,2'd0,2'd0), 4);
    add(0, JALR, 1, 0, cw(0,0,0,0,0,1,0, 2'd0,2'd0,2'd0,2'd0,2'd0), 4);
    // jal
    add(0, JAL, 1, 0, cw(1,0,0,1,1,0,0, 2'd0,2'd2,2'd0,2'd2,2'd3), 5);
    add(0, JAL, 1, 0, cw(0,0,0,0,0,0,0, 2'd1,2'd1,2'd0,2'd0,2'd3), 5);
    add(0, JAL, 0, 0, cw(0,0,0,0,1,0,0, 2'd1,2'd2,2'd0,2'd0,2'd3), 5);
    add(0, JAL, 1, 0, cw(0,0,0,0,0,1,0, 2'd0,2'd0,2'd0,2'd0,2'd3), 5);
    // I-type ALU
    add(0, IA, 1, 0, cw(1,0,0,1,1,0,0, 2'd0,2'd2,2'd0,2'd2,2'd0), 6);
    add(0, IA, 1, 0, cw(0,0,0,0,0,0,0, 2'd1,2'd1,2'd0,2'd0,2'd0), 6);
    add(0, IA, 1, 0, cw(0,0,0,0,0,0,0, 2'd2,2'd1,2'd2,2'd0,2'd0), 6);
    add(0, IA, 1, 0, cw(0,0,0,0,0,1,0, 2'd0,2'd0,2'd0,2'd0,2'd0), 6);
    // Test 5: unsupported opcode traps without counting
    add(0, BAD, 1, 0, cw(1,0,0,1,1,0,0, 2'd0,2'd2,2'd0,2'd2,2'd0), 7);
    add(0, BAD, 1, 1, cw(0,0,0,0,0,0,0, 2'd1,2'd1,2'd0,2'd0,2'd0), 7);
    add(0, BAD, 1, 1, cw(0,0,0,0,0,0,1, 2'd0,2'd0,2'd0,2'd0,2'd0), 7);
    // sw zero-wait
    add(0, SW, 1, 0, cw(1,0,0,1,1,0,0, 2'd0,2'd2,2'd0,2'd2,2'd1), 7);
    add(0, SW, 1, 0, cw(0,0,0,0,0,0,0, 2'd1,2'd1,2'd0,2'd0,2'd1), 7);
    add(0, SW, 1, 0, cw(0,0,0,0,0,0,0, 2'd2,2'd1,2'd0,2'd0,2'd1), 7);
    add(0, SW, 1, 0, cw(1,1,1,0,0,0,0, 2'd0,2'd0,2'd0,2'd0,2'd1), 7);
    // Test 6: sw stalled in MEMWRITE, reset kills the store
    add(0, SW, 1, 0, cw(1,0,0,1,1,0,0, 2'd0,2'd2,2'd0,2'd2,2'd1), 8);
    add(0, SW, 1, 0, cw(0,0,0,0,0,0,0, 2'd1,2'd1,2'd0,2'd0,2'd1), 8);
    add(0, SW, 1, 0, cw(0,0,0,0,0,0,0, 2'd2,2'd1,2'd0,2'd0,2'd1), 8);
    add(0, SW, 0, 0, cw(1,1,1,0,0,0,0, 2'd0,2'd0,2'd0,2'd0,2'd1), 8);
    add(1, SW, 0, 0, cw(0,0,1,0,0,0,0, 2'd0,2'd0,2'd0,2'd0,2'd1), 8);
    add(0, R,  0, 0, cw(1,0,0,0,0,0,0, 2'd0,2'd2,2'd0,2'd2,2'd0), 0);

    // Reset: strobes forced low even though the state is FETCH with MemReady high
    rst = 1'b1; op = R; MemReady = 1'b1; Zero = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("reset strobes", {26'd0, MemReq, MemWrite, IRWrite, PCWrite, RegWrite, Illegal}, 32'd0);
    chk("reset count", InstrCount, 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; op = vecs[i].op; MemReady = vecs[i].rdy; Zero = vecs[i].zero;
      @(negedge clk);
      chk($sformatf("vec%0d ctrl", i), {15'd0, act_word()}, {15'd0, vecs[i].word});
      chk($sformatf("vec%0d count", i), InstrCount, vecs[i].cnt);
      @(posedge clk); #1;
    end

    // Zero-wait fetch-to-fetch latency, starting from FETCH
    latency(R, 4);
    latency(IA, 4);
    latency(SW, 4);
    latency(BEQ, 3);
    latency(LW, 5);
    chk("count after latency runs", InstrCount, 32'd5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
